// File: rtl/trax_pkg.sv
// Shared definitions for the Trax move engine: move word layout, tile and
// colour codes, engine handshake bit indices and the sequencer state encoding.
package trax_pkg;

   localparam int MOVE_W = 22;

   localparam logic [1:0] TILE_EMPTY  = 2'd0;
   localparam logic [1:0] TILE_PLUS   = 2'd1;
   localparam logic [1:0] TILE_SLASH  = 2'd2;
   localparam logic [1:0] TILE_BSLASH = 2'd3;

   localparam logic COLOR_WHITE = 1'b0;
   localparam logic COLOR_BLACK = 1'b1;

   localparam int ENG_LOAD   = 0;
   localparam int ENG_AUTO   = 1;
   localparam int ENG_COMMIT = 2;
   localparam int ENG_SHDN   = 3;
   localparam int ENG_SHRT   = 4;
   localparam int ENG_CHOOSE = 5;
   localparam int ENG_N      = 6;

   // White's opening move: a plus tile at the origin.
   localparam logic [MOVE_W-1:0] OPEN_MOVE = {TILE_PLUS, 10'd0, 10'd0};

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_AUTO, ST_COMMIT, ST_SHDN, ST_SHRT, ST_CHOOSE, ST_SEND
   } seq_state_t;

   // Whose move is currently being applied to the board.
   typedef enum logic {PASS_OPP, PASS_OWN} pass_t;

   // One-hot engine start vector belonging to a state; zero for non-engine states.
   function automatic logic [ENG_N-1:0] start_vec(seq_state_t s);
      logic [ENG_N-1:0] v;
      v = '0;
      case (s)
         ST_LOAD:   v[ENG_LOAD]   = 1'b1;
         ST_AUTO:   v[ENG_AUTO]   = 1'b1;
         ST_COMMIT: v[ENG_COMMIT] = 1'b1;
         ST_SHDN:   v[ENG_SHDN]   = 1'b1;
         ST_SHRT:   v[ENG_SHRT]   = 1'b1;
         ST_CHOOSE: v[ENG_CHOOSE] = 1'b1;
         default:   v = '0;
      endcase
      return v;
   endfunction

   // After the board settles: the opponent's move needs a reply, our own move is sent.
   function automatic seq_state_t post_commit(pass_t p);
      return (p == PASS_OWN) ? ST_SEND : ST_CHOOSE;
   endfunction

endpackage

// File: rtl/trax_step_sequencer_if.sv
// Handshake bundle between the sequencer, the transceiver and the board engines.
interface trax_step_sequencer_if;
   import trax_pkg::*;

   logic              rx_valid;
   logic              rx_color;
   logic [MOVE_W-1:0] rx_move;
   logic [ENG_N-1:0]  eng_start;
   logic [ENG_N-1:0]  eng_done;
   logic [MOVE_W-1:0] eng_move;
   logic              ac_changed;
   logic              grow_down;
   logic              grow_right;
   logic [MOVE_W-1:0] chosen_move;
   logic              tx_start;
   logic [MOVE_W-1:0] tx_move;
   logic              busy;
   logic              error;
   logic              overrun;

   modport slave (
      input  rx_valid, rx_color, rx_move, eng_done, ac_changed, grow_down, grow_right, chosen_move,
      output eng_start, eng_move, tx_start, tx_move, busy, error, overrun
   );

   modport master (
      output rx_valid, rx_color, rx_move, eng_done, ac_changed, grow_down, grow_right, chosen_move,
      input  eng_start, eng_move, tx_start, tx_move, busy, error, overrun
   );

endinterface

// File: rtl/trax_phase_watchdog.sv
// Per-phase timeout: counts cycles since the last engine start and flags
// expiry once WD_CYCLES cycles (start cycle included) have elapsed.
module trax_phase_watchdog #(
   parameter int WD_CYCLES = 8192
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic expire
);
   localparam int               CNT_W = $clog2(WD_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WD_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count up from the start cycle and saturate; a new start restarts the count.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= CNT_W'(1);
      else if (cnt != LAST)
         cnt <= cnt + CNT_W'(1);
   end

   // The start cycle itself never expires: cnt is stale until the clear lands.
   assign expire = (cnt == LAST) && !clear;

endmodule

// File: rtl/trax_step_sequencer.sv
// Per-turn phase scheduler for the Trax move engine.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | waiting for an opponent move or game start
//  LOAD      | LOAD engine placing eng_move on the board
//  AUTO      | autocomplete pass; repeats while the board keeps changing
//  COMMIT    | commit board, report whether row 0 / col 0 got a tile
//  SHDN      | shift board down one row
//  SHRT      | shift board right one column
//  CHOOSE    | pick our reply, which is then loaded like any other move
//  SEND      | hand our move to the transmitter
module trax_step_sequencer
   import trax_pkg::*;
#(
   parameter int AC_MAX_ITER = 64,
   parameter int WD_CYCLES   = 8192
) (
   input  logic                  clk,
   input  logic                  reset,
   trax_step_sequencer_if.slave  bus
);
   localparam int                ITER_W    = $clog2(AC_MAX_ITER + 1);
   localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(AC_MAX_ITER - 1);

   seq_state_t        state;
   pass_t             pass_q;
   logic              first;
   logic              grow_right_q;
   logic [ITER_W-1:0] iter;
   logic              wd_expire;
   logic              eng_hit;

   // Only the done bit of the engine we are waiting on counts.
   assign eng_hit  = |(bus.eng_done & start_vec(state));
   assign bus.busy = (state != ST_IDLE);

   trax_phase_watchdog #(.WD_CYCLES(WD_CYCLES)) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (|bus.eng_start),
      .expire (wd_expire)
   );

   // Phase sequencing with registered start/transmit pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         pass_q        <= PASS_OPP;
         first         <= 1'b1;
         grow_right_q  <= 1'b0;
         iter          <= '0;
         bus.eng_start <= '0;
         bus.eng_move  <= '0;
         bus.tx_start  <= 1'b0;
         bus.tx_move   <= '0;
         bus.error     <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         bus.eng_start <= '0;
         bus.tx_start  <= 1'b0;
         if (bus.rx_valid && state != ST_IDLE)
            bus.overrun <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (bus.rx_valid) begin
                  first <= 1'b0;
                  if (first && bus.rx_color == COLOR_WHITE) begin
                     pass_q       <= PASS_OWN;
                     bus.eng_move <= OPEN_MOVE;
                  end else begin
                     pass_q       <= PASS_OPP;
                     bus.eng_move <= bus.rx_move;
                  end
                  state         <= ST_LOAD;
                  bus.eng_start <= start_vec(ST_LOAD);
               end
            end
            ST_SEND: begin
               bus.tx_start <= 1'b1;
               bus.tx_move  <= bus.eng_move;
               state        <= ST_IDLE;
            end
            default: begin
               if (eng_hit) begin
                  case (state)
                     ST_LOAD: begin
                        iter          <= '0;
                        state         <= ST_AUTO;
                        bus.eng_start <= start_vec(ST_AUTO);
                     end
                     ST_AUTO: begin
                        if (!bus.ac_changed) begin
                           state         <= ST_COMMIT;
                           bus.eng_start <= start_vec(ST_COMMIT);
                        end else if (iter == ITER_LAST) begin
                           bus.error <= 1'b1;
                           state     <= ST_IDLE;
                        end else begin
                           iter          <= iter + ITER_W'(1);
                           bus.eng_start <= start_vec(ST_AUTO);
                        end
                     end
                     ST_COMMIT: begin
                        grow_right_q <= bus.grow_right;
                        if (bus.grow_down) begin
                           state         <= ST_SHDN;
                           bus.eng_start <= start_vec(ST_SHDN);
                        end else if (bus.grow_right) begin
                           state         <= ST_SHRT;
                           bus.eng_start <= start_vec(ST_SHRT);
                        end else begin
                           state         <= post_commit(pass_q);
                           bus.eng_start <= start_vec(post_commit(pass_q));
                        end
                     end
                     ST_SHDN: begin
                        if (grow_right_q) begin
                           state         <= ST_SHRT;
                           bus.eng_start <= start_vec(ST_SHRT);
                        end else begin
                           state         <= post_commit(pass_q);
                           bus.eng_start <= start_vec(post_commit(pass_q));
                        end
                     end
                     ST_SHRT: begin
                        state         <= post_commit(pass_q);
                        bus.eng_start <= start_vec(post_commit(pass_q));
                     end
                     ST_CHOOSE: begin
                        bus.eng_move  <= bus.chosen_move;
                        pass_q        <= PASS_OWN;
                        state         <= ST_LOAD;
                        bus.eng_start <= start_vec(ST_LOAD);
                     end
                     default: state <= ST_IDLE;
                  endcase
               end else if (wd_expire) begin
                  bus.error <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trax_step_sequencer.sv
// Bench for trax_step_sequencer: table of whole turns plus hand-written
// fixpoint, watchdog and mid-turn reset sequences. A single negedge-driven
// task plays the engines and checks starts and transmits against queues
// filled by a small turn model.
`timescale 1ns/1ps
module tb_trax_step_sequencer;
   import trax_pkg::*;

   localparam int AC_MAX = 4;
   localparam int WD     = 16;
   localparam int NT     = 5;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   trax_step_sequencer_if bus_if ();

   trax_step_sequencer #(.AC_MAX_ITER(AC_MAX), .WD_CYCLES(WD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   typedef struct {
      logic              color;
      logic [MOVE_W-1:0] move;
      int                n_ac;
      logic              gd;
      logic              gr;
      logic [MOVE_W-1:0] chosen;
      int                lat;
   } turn_t;

   typedef struct {
      int                eng;
      logic [MOVE_W-1:0] move;
   } start_t;

   start_t            exp_st_q[$];
   logic [MOVE_W-1:0] exp_tx_q[$];
   turn_t             tbl[NT];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int                cfg_n_ac, cfg_lat;
   logic              cfg_gd, cfg_gr;
   logic [MOVE_W-1:0] cfg_chosen;
   logic [ENG_N-1:0]  hang_mask;
   logic              pend;
   logic [ENG_N-1:0]  pend_bit;
   int                pend_cnt, ac_idx;
   int                t_choose, n_auto_seen, n_tx_seen;
   logic              first_model;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: engine responder, start scoreboard and transmit scoreboard.
   task automatic tick();
      start_t e;
      @(negedge clk);
      cyc++;
      bus_if.eng_done   = '0;
      bus_if.ac_changed = 1'b0;
      bus_if.grow_down  = 1'b0;
      bus_if.grow_right = 1'b0;
      if (bus_if.eng_start != '0) begin
         chk("start_onehot", 32'($onehot(bus_if.eng_start)), 1);
         if (exp_st_q.size() == 0)
            chk("unexpected_start", 32'(bus_if.eng_start), 0);
         else begin
            e = exp_st_q.pop_front();
            chk("start_engine", 32'(bus_if.eng_start), 32'(1) << e.eng);
            if (e.eng == ENG_LOAD)
               chk("load_move", 32'(bus_if.eng_move), 32'(e.move));
         end
         if (bus_if.eng_start[ENG_CHOOSE]) t_choose = cyc;
         if (bus_if.eng_start[ENG_AUTO])   n_auto_seen++;
         if (bus_if.eng_start[ENG_LOAD])   ac_idx = 0;
         pend     = 1'b1;
         pend_bit = bus_if.eng_start;
         pend_cnt = cfg_lat;
      end else if (pend && pend_cnt > 0) begin
         pend_cnt--;
      end
      if (pend && pend_cnt == 0 && (pend_bit & hang_mask) == '0) begin
         bus_if.eng_done = pend_bit;
         pend = 1'b0;
         if (pend_bit[ENG_AUTO]) begin
            bus_if.ac_changed = (ac_idx < cfg_n_ac);
            ac_idx++;
         end
         if (pend_bit[ENG_COMMIT]) begin
            bus_if.grow_down  = cfg_gd;
            bus_if.grow_right = cfg_gr;
         end
         if (pend_bit[ENG_CHOOSE]) bus_if.chosen_move = cfg_chosen;
      end
      if (bus_if.tx_start) begin
         n_tx_seen++;
         if (exp_tx_q.size() == 0)
            chk("unexpected_tx", 32'(bus_if.tx_start), 0);
         else
            chk("tx_move", 32'(bus_if.tx_move), 32'(exp_tx_q.pop_front()));
      end
   endtask

   task automatic push_start(input int eng, input logic [MOVE_W-1:0] mv);
      start_t e;
      e.eng  = eng;
      e.move = mv;
      exp_st_q.push_back(e);
   endtask

   task automatic push_phase(input turn_t t);
      for (int i = 0; i <= t.n_ac; i++) push_start(ENG_AUTO, '0);
      push_start(ENG_COMMIT, '0);
      if (t.gd) push_start(ENG_SHDN, '0);
      if (t.gr) push_start(ENG_SHRT, '0);
   endtask

   // Expected engine order and transmitted move for one complete turn.
   task automatic plan_turn(input turn_t t);
      logic own;
      own = first_model && (t.color == 1'b0);
      push_start(ENG_LOAD, own ? 22'h100000 : t.move);
      push_phase(t);
      if (!own) begin
         push_start(ENG_CHOOSE, '0);
         push_start(ENG_LOAD, t.chosen);
         push_phase(t);
      end
      exp_tx_q.push_back(own ? 22'h100000 : t.chosen);
      first_model = 1'b0;
      cfg_n_ac    = t.n_ac;
      cfg_lat     = t.lat;
      cfg_gd      = t.gd;
      cfg_gr      = t.gr;
      cfg_chosen  = t.chosen;
   endtask

   task automatic pulse_rx(input logic color, input logic [MOVE_W-1:0] mv);
      bus_if.rx_valid = 1'b1;
      bus_if.rx_color = color;
      bus_if.rx_move  = mv;
      tick();
      bus_if.rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!bus_if.busy && exp_st_q.size() == 0 && exp_tx_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk({name, "_complete"}, 32'(ok), 1);
      exp_st_q.delete();
      exp_tx_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pend  = 1'b0;
      bus_if.rx_valid = 1'b0;
      tick();
      tick();
      reset       = 1'b0;
      first_model = 1'b1;
      hang_mask   = '0;
      exp_st_q.delete();
      exp_tx_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      //           color  move        n_ac gd    gr    chosen      lat
      tbl[0] = '{1'b0, 22'h03ffff, 0, 1'b0, 1'b0, 22'h000000, 3};
      tbl[1] = '{1'b1, 22'h200401, 2, 1'b0, 1'b0, 22'h100002, 1};
      tbl[2] = '{1'b0, 22'h100405, 0, 1'b1, 1'b1, 22'h300c03, 2};
      tbl[3] = '{1'b1, 22'h2ffc01, 1, 1'b1, 1'b0, 22'h100801, 0};
      tbl[4] = '{1'b0, 22'h301402, 3, 1'b0, 1'b1, 22'h200007, 5};

      reset = 1'b1;
      bus_if.rx_valid    = 1'b0;
      bus_if.rx_color    = 1'b0;
      bus_if.rx_move     = '0;
      bus_if.eng_done    = '0;
      bus_if.ac_changed  = 1'b0;
      bus_if.grow_down   = 1'b0;
      bus_if.grow_right  = 1'b0;
      bus_if.chosen_move = '0;
      hang_mask = '0;
      pend = 1'b0; pend_bit = '0; pend_cnt = 0; ac_idx = 0;
      cfg_n_ac = 0; cfg_lat = 1; cfg_gd = 1'b0; cfg_gr = 1'b0; cfg_chosen = '0;
      t_choose = -1; n_auto_seen = 0; n_tx_seen = 0;
      first_model = 1'b1;

      repeat (3) tick();
      chk("rst_busy",      32'(bus_if.busy), 0);
      chk("rst_error",     32'(bus_if.error), 0);
      chk("rst_overrun",   32'(bus_if.overrun), 0);
      chk("rst_eng_start", 32'(bus_if.eng_start), 0);
      chk("rst_tx_start",  32'(bus_if.tx_start), 0);
      chk("rst_tx_move",   32'(bus_if.tx_move), 0);
      chk("rst_eng_move",  32'(bus_if.eng_move), 0);
      reset = 1'b0;
      tick();

      // Whole turns: white opening, black reply, every grow combination, zero-latency engines.
      for (int i = 0; i < NT; i++) begin
         plan_turn(tbl[i]);
         pulse_rx(tbl[i].color, tbl[i].move);
         wait_idle("turn");
         chk("turn_error",   32'(bus_if.error), 0);
         chk("turn_overrun", 32'(bus_if.overrun), 0);
      end

      // Autocomplete never settles: error after the AC_MAX-th pass, nothing sent.
      cfg_n_ac = 1000; cfg_lat = 1; cfg_gd = 1'b0; cfg_gr = 1'b0;
      push_start(ENG_LOAD, 22'h0c0203);
      for (int i = 0; i < AC_MAX; i++) push_start(ENG_AUTO, '0);
      n_auto_seen = 0; n_tx_seen = 0;
      pulse_rx(1'b1, 22'h0c0203);
      wait_idle("fixpoint");
      repeat (5) tick();
      chk("fix_error",    32'(bus_if.error), 1);
      chk("fix_auto_cnt", 32'(n_auto_seen), AC_MAX);
      chk("fix_no_tx",    32'(n_tx_seen), 0);
      chk("fix_busy",     32'(bus_if.busy), 0);
      do_reset();
      chk("clr_error",    32'(bus_if.error), 0);

      // CHOOSE never answers: watchdog fires WD cycles after its start; a mid-turn rx is an overrun.
      cfg_n_ac = 0; cfg_lat = 2; cfg_gd = 1'b0; cfg_gr = 1'b0;
      hang_mask = '0;
      hang_mask[ENG_CHOOSE] = 1'b1;
      push_start(ENG_LOAD, 22'h100203);
      push_start(ENG_AUTO, '0);
      push_start(ENG_COMMIT, '0);
      push_start(ENG_CHOOSE, '0);
      first_model = 1'b0;
      t_choose = -1; n_tx_seen = 0;
      pulse_rx(1'b1, 22'h100203);
      for (int k = 0; k < 100 && t_choose < 0; k++) tick();
      chk("wd_choose_started", 32'(t_choose >= 0), 1);
      if (t_choose >= 0) begin
         while (cyc < t_choose + WD) begin
            bus_if.rx_valid = (cyc == t_choose + 4);
            if (cyc == t_choose + WD - 1) chk("wd_not_early", 32'(bus_if.error), 0);
            tick();
         end
         bus_if.rx_valid = 1'b0;
         chk("wd_error",   32'(bus_if.error), 1);
         chk("wd_idle",    32'(bus_if.busy), 0);
         chk("wd_overrun", 32'(bus_if.overrun), 1);
      end
      repeat (3) tick();
      chk("wd_no_tx", 32'(n_tx_seen), 0);
      do_reset();
      chk("clr_overrun", 32'(bus_if.overrun), 0);

      // Reset in the middle of AUTO aborts the turn; the next white rx is a fresh opening.
      cfg_n_ac = 2; cfg_lat = 3; cfg_gd = 1'b0; cfg_gr = 1'b0;
      push_start(ENG_LOAD, 22'h000401);
      push_start(ENG_AUTO, '0);
      first_model = 1'b0;
      n_auto_seen = 0; n_tx_seen = 0;
      pulse_rx(1'b1, 22'h000401);
      for (int k = 0; k < 50 && n_auto_seen == 0; k++) tick();
      chk("rst_mid_auto_seen", 32'(n_auto_seen), 1);
      reset = 1'b1;
      pend  = 1'b0;
      tick();
      chk("rst_mid_busy",      32'(bus_if.busy), 0);
      chk("rst_mid_eng_start", 32'(bus_if.eng_start), 0);
      chk("rst_mid_tx_start",  32'(bus_if.tx_start), 0);
      reset = 1'b0;
      exp_st_q.delete();
      exp_tx_q.delete();
      first_model = 1'b1;
      tick();
      plan_turn('{1'b0, 22'h00ffff, 1, 1'b1, 1'b0, 22'h000000, 2});
      pulse_rx(1'b0, 22'h00ffff);
      wait_idle("restart");
      chk("restart_tx_count", 32'(n_tx_seen), 1);
      chk("restart_error",    32'(bus_if.error), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
